// File: rtl/ram256_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram256_arbiter_pkg
// Brief   : Shared widths and FSM encoding for the RAM256 arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package ram256_arbiter_pkg;

    localparam int WSIZE_DEF = 4;
    localparam int DW        = WSIZE_DEF * 8;
    localparam int AW        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram256_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ram256_arbiter_if
// Brief   : Two req/ack requester ports plus the RAM256 macro pins.
// Revision: 1.0 - initial release
// ============================================================================
interface ram256_arbiter_if #(
    parameter int WSIZE = ram256_arbiter_pkg::WSIZE_DEF
);
    localparam int DATA_W = WSIZE * 8;
    localparam int ADDR_W = ram256_arbiter_pkg::AW;

    logic              p0_req;
    logic [WSIZE-1:0]  p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic [WSIZE-1:0]  p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic              ram_en;
    logic [WSIZE-1:0]  ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/ram256_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Combinational two-input round-robin picker; ties go to !last.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic            gnt_valid,
    output logic            gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ~last : req[1];
    end

endmodule
`default_nettype wire

// File: rtl/ram256_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram256_arbiter
// Brief   : Round-robin arbiter/sequencer for one single-port RAM256 macro.
// Revision: 1.0 - initial release
// ============================================================================
module ram256_arbiter
    import ram256_arbiter_pkg::*;
#(
    parameter int WSIZE = WSIZE_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ram256_arbiter_if.slave    bus
);

    localparam int DATA_W = WSIZE * 8;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rr_last;
    logic                r_req_id;
    logic [WSIZE-1:0]    r_req_we;
    logic [AW-1:0]       r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic                r_ram_en;
    logic [WSIZE-1:0]    r_ram_we;
    logic                r_p0_ack;
    logic                r_p1_ack;
    logic [DATA_W-1:0]   r_p0_rdata;
    logic [DATA_W-1:0]   r_p1_rdata;

    logic                w_gnt_valid;
    logic                w_gnt_id;
    logic                w_load;
    logic                w_rsp;
    logic [WSIZE-1:0]    w_sel_we;
    logic [AW-1:0]       w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req       ({bus.p1_req, bus.p0_req}),
        .last      (r_rr_last),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    always_comb begin
        w_sel_we    = w_gnt_id ? bus.p1_we    : bus.p0_we;
        w_sel_addr  = w_gnt_id ? bus.p1_addr  : bus.p0_addr;
        w_sel_wdata = w_gnt_id ? bus.p1_wdata : bus.p0_wdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rsp       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = ACC;
                    w_load      = 1'b1;
                end
            end
            ACC:     w_state_nxt = RSP;
            RSP: begin
                w_state_nxt = IDLE;
                w_rsp       = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request registers double as the RAM address/data pins; ram_we is kept
    // separately so it can be forced low outside the single ACC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_id    <= 1'b0;
            r_req_we    <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= '0;
        end else begin
            r_ram_en <= w_load;
            r_ram_we <= w_load ? w_sel_we : '0;
            if (w_load) begin
                r_req_id    <= w_gnt_id;
                r_req_we    <= w_sel_we;
                r_req_addr  <= w_sel_addr;
                r_req_wdata <= w_sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last  <= 1'b1;
            r_p0_ack   <= 1'b0;
            r_p1_ack   <= 1'b0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            r_p0_ack <= w_rsp & ~r_req_id;
            r_p1_ack <= w_rsp &  r_req_id;
            if (w_rsp) begin
                r_rr_last <= r_req_id;
                if (r_req_we == '0) begin
                    if (r_req_id) begin
                        r_p1_rdata <= bus.ram_rdata;
                    end else begin
                        r_p0_rdata <= bus.ram_rdata;
                    end
                end
            end
        end
    end

    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_req_addr;
    assign bus.ram_wdata = r_req_wdata;
    assign bus.p0_ack    = r_p0_ack;
    assign bus.p1_ack    = r_p1_ack;
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram256_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram256_arbiter
// Brief   : Self-checking bench for ram256_arbiter with a behavioural RAM256.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram256_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ram256_arbiter_if #(.WSIZE(4)) bus ();

    ram256_arbiter #(.WSIZE(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM256: registered read, byte-lane writes.
    logic [31:0] mem [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_we[b]) mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
            end
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        bit          port;
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_p0;
        logic [31:0] exp_p1;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input logic [3:0] we,
                         input logic [7:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called on a falling edge; returns on the falling edge after the ack cycle.
    task automatic txn(input string tag, input bit port, input logic [3:0] we,
                       input logic [7:0] addr, input logic [31:0] wdata);
        int         lat = 0;
        int         en_cnt = 0;
        int         busy_cnt = 0;
        int         other_ack = 0;
        bit         got = 0;
        logic [7:0] cap_addr = 8'h00;
        logic [3:0] cap_we = 4'h0;
        drive(port, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.ram_en) begin
                en_cnt++;
                cap_addr = bus.ram_addr;
                cap_we   = bus.ram_we;
            end
            if (bus.busy) busy_cnt++;
            if (port ? bus.p0_ack : bus.p1_ack) other_ack++;
            if (port ? bus.p1_ack : bus.p0_ack) begin
                got = 1;
                lat = c;
                break;
            end
        end
        drive(port, 1'b0, 4'h0, 8'h00, 32'h0);
        check({tag, " ack_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, lat, 3);
        check({tag, " ram_en_cycles"}, en_cnt, 1);
        check({tag, " busy_cycles"}, busy_cnt, 2);
        check({tag, " other_ack"}, other_ack, 0);
        check({tag, " ram_addr"}, {24'h0, cap_addr}, {24'h0, addr});
        check({tag, " ram_we"}, {28'h0, cap_we}, {28'h0, we});
        @(negedge clk);
        check({tag, " ack_one_cycle"}, {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
    endtask

    initial begin
        //           port we     addr   wdata         exp_p0        exp_p1
        vecs[0] = '{1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
        vecs[1] = '{1'b0, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF, 32'h00000000};
        vecs[2] = '{1'b1, 4'hF, 8'hFF, 32'h11223344, 32'hDEADBEEF, 32'h00000000};
        vecs[3] = '{1'b1, 4'h4, 8'hFF, 32'h00AB0000, 32'hDEADBEEF, 32'h00000000};
        vecs[4] = '{1'b1, 4'h0, 8'hFF, 32'h0,        32'hDEADBEEF, 32'h11AB3344};
        vecs[5] = '{1'b0, 4'hF, 8'h05, 32'hCAFEF00D, 32'hDEADBEEF, 32'h11AB3344};
        vecs[6] = '{1'b1, 4'h0, 8'h05, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 4'hF, 8'h05, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 4'h0, 8'h05, 32'h0,        32'h12345678, 32'hCAFEF00D};
        vecs[9] = '{1'b1, 4'h0, 8'h05, 32'h0,        32'h12345678, 32'h12345678};

        drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst ram_en", {31'h0, bus.ram_en}, 32'h0);
        check("rst ram_we", {28'h0, bus.ram_we}, 32'h0);
        check("rst ram_addr", {24'h0, bus.ram_addr}, 32'h0);
        check("rst ram_wdata", bus.ram_wdata, 32'h0);
        check("rst acks", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
        check("rst p0_rdata", bus.p0_rdata, 32'h0);
        check("rst p1_rdata", bus.p1_rdata, 32'h0);
        check("rst busy", {31'h0, bus.busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d p0_rdata", i), bus.p0_rdata, vecs[i].exp_p0);
            check($sformatf("vec%0d p1_rdata", i), bus.p1_rdata, vecs[i].exp_p1);
        end

        // Continuous contention right after reset: p0 first, then strict alternation.
        begin
            int   ids [$];
            int   last_ack [2] = '{0, 0};
            int   max_gap = 0;
            do_reset();
            drive(1'b0, 1'b1, 4'h0, 8'h10, 32'h0);
            drive(1'b1, 1'b1, 4'h0, 8'hFF, 32'h0);
            for (int c = 1; c <= 40 && ids.size() < 6; c++) begin
                @(negedge clk);
                if (bus.p0_ack) begin
                    ids.push_back(0);
                    check("contend p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
                    if (c - last_ack[0] > max_gap) max_gap = c - last_ack[0];
                    last_ack[0] = c;
                end
                if (bus.p1_ack) begin
                    ids.push_back(1);
                    check("contend p1_rdata", bus.p1_rdata, 32'h11AB3344);
                    if (c - last_ack[1] > max_gap) max_gap = c - last_ack[1];
                    last_ack[1] = c;
                end
            end
            drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
            check("contend ack_count", ids.size(), 6);
            for (int k = 0; k < ids.size(); k++) check($sformatf("contend order%0d", k), ids[k], k % 2);
            check("contend max_wait_le6", 32'(max_gap <= 6), 32'd1);
            repeat (2) @(negedge clk);
        end

        // Requester drops req and changes addr right after the grant.
        begin
            int   acks = 0;
            int   bad_addr = 0;
            txn("pre80", 1'b0, 4'hF, 8'h80, 32'h80808080);
            drive(1'b0, 1'b1, 4'h0, 8'h80, 32'h0);
            @(negedge clk);
            check("drop ram_en_after_grant", {31'h0, bus.ram_en}, 32'h1);
            check("drop ram_addr", {24'h0, bus.ram_addr}, 32'h80);
            drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.ram_en && bus.ram_addr != 8'h80) bad_addr++;
                if (bus.p0_ack) acks++;
            end
            check("drop ack_count", acks, 1);
            check("drop addr_stable", bad_addr, 0);
            check("drop p0_rdata", bus.p0_rdata, 32'h80808080);
        end

        // Asynchronous reset in the ACC cycle of a p1 write.
        begin
            int p1_acks = 0;
            int first = -1;
            drive(1'b1, 1'b1, 4'hF, 8'h20, 32'hAAAA5555);
            @(negedge clk);
            check("abort in_acc", {31'h0, bus.ram_en}, 32'h1);
            rst_n = 1'b0;
            #1;
            check("abort ram_en", {31'h0, bus.ram_en}, 32'h0);
            check("abort ram_we", {28'h0, bus.ram_we}, 32'h0);
            check("abort acks", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
            check("abort busy", {31'h0, bus.busy}, 32'h0);
            drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (bus.p1_ack) p1_acks++;
            end
            check("abort no_p1_ack", p1_acks, 0);
            check("abort idle_after", {31'h0, bus.busy}, 32'h0);
            drive(1'b0, 1'b1, 4'h0, 8'h10, 32'h0);
            drive(1'b1, 1'b1, 4'h0, 8'hFF, 32'h0);
            for (int c = 0; c < 10 && first < 0; c++) begin
                @(negedge clk);
                if (bus.p0_ack) first = 0;
                else if (bus.p1_ack) first = 1;
            end
            drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            drive(1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
            check("abort next_tie_winner", first, 0);
            repeat (3) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
